// File: rtl/pmp.sv
// Physical memory protection checker: decides whether an access is allowed from the
// per-entry address/config registers, registered on clk_i. Define PMP_TOR_EN to enable TOR matching.
module pmp #(
  parameter int unsigned PLEN       = 34,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [PLEN-1:0]                      addr_i,
  input  logic [2:0]                           access_type_i,
  input  logic [1:0]                           priv_lvl_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]   conf_addr_i,
  input  logic [NR_ENTRIES-1:0][7:0]           conf_i,
  output logic                                 allow_o
);

  // Word addresses are compared at a width wide enough for both operands.
  localparam int unsigned WW = (PLEN - 2 > PMP_LEN) ? PLEN - 2 : PMP_LEN;

  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TOR   = 2'd1,
    MODE_NA4   = 2'd2,
    MODE_NAPOT = 2'd3
  } addr_mode_e;

  typedef struct packed {
    logic       locked;
    logic [1:0] reserved;
    addr_mode_e addr_mode;
    logic [2:0] access_type;
  } pmpcfg_t;

  logic [WW-1:0]         addr_word;
  pmpcfg_t               cfg [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] match;
  logic [NR_ENTRIES-1:0] unused_rsvd;
  logic                  unused_addr_lsb;
  logic                  allow_d;

  assign addr_word       = WW'(addr_i[PLEN-1:2]);
  assign unused_addr_lsb = ^addr_i[1:0];

  for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
    logic [WW-1:0] conf_word;
    logic [WW-1:0] napot_mask;
    logic          napot_all;
    logic          hit;

    assign cfg[i]         = pmpcfg_t'(conf_i[i]);
    assign unused_rsvd[i] = ^cfg[i].reserved;
    assign conf_word      = WW'(conf_addr_i[i]);
    assign napot_all      = &conf_addr_i[i];
    // x ^ (x+1) sets exactly bits [t:0] where t is the count of trailing ones.
    assign napot_mask     = napot_all ? '1
                          : WW'(conf_addr_i[i] ^ (conf_addr_i[i] + PMP_LEN'(1)));

`ifdef PMP_TOR_EN
    logic [PLEN-1:0] tor_lo;
    logic [PLEN-1:0] tor_hi;

    assign tor_hi = PLEN'({conf_addr_i[i], 2'b00});
    if (i == 0) begin : g_lo_zero
      assign tor_lo = '0;
    end else begin : g_lo_prev
      assign tor_lo = PLEN'({conf_addr_i[i-1], 2'b00});
    end
`endif

    always_comb begin
      hit = 1'b0;
      case (cfg[i].addr_mode)
        MODE_NA4:   hit = (addr_word == conf_word);
        MODE_NAPOT: hit = (((addr_word ^ conf_word) & ~napot_mask) == '0);
`ifdef PMP_TOR_EN
        // An empty range (lo >= hi) can never satisfy both bounds.
        MODE_TOR:   hit = (addr_i >= tor_lo) && (addr_i < tor_hi);
`else
        MODE_TOR:   hit = 1'b0;
`endif
        default:    hit = 1'b0;
      endcase
    end

    assign match[i] = hit;
  end

  // Lowest-numbered matching entry decides; no match falls back to privilege.
  always_comb begin
    logic found;
    // NOTE: combinational logic uses blocking assignments, each output defaulted first so no latch is inferred.
    found   = 1'b0;
    allow_d = (priv_lvl_i == PRIV_M);
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (!found && match[i]) begin
        found = 1'b1;
        if (priv_lvl_i == PRIV_M && !cfg[i].locked) begin
          allow_d = 1'b1;
        end else begin
          allow_d = ((access_type_i & cfg[i].access_type) == access_type_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      allow_o <= 1'b0;
    end else begin
      allow_o <= allow_d;
    end
  end

endmodule

// File: tb/tb_pmp.sv
// Self-checking bench for pmp: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural region model.
module tb_pmp;

  localparam int PLEN    = 34;
  localparam int PMP_LEN = 32;
  localparam int N       = 4;

`ifdef PMP_TOR_EN
  localparam bit TOR_EN = 1'b1;
`else
  localparam bit TOR_EN = 1'b0;
`endif

  logic                        clk;
  logic                        rst;
  logic [PLEN-1:0]             addr;
  logic [2:0]                  acc;
  logic [1:0]                  priv;
  logic [N-1:0][PMP_LEN-1:0]   ca;
  logic [N-1:0][7:0]           cf;
  logic                        allow;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  pmp #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .addr_i        (addr),
    .access_type_i (acc),
    .priv_lvl_i    (priv),
    .conf_addr_i   (ca),
    .conf_i        (cf),
    .allow_o       (allow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Region model: each entry is turned into a byte range [lo, hi) and tested with plain arithmetic.
  function automatic bit model(input longint a, input bit [2:0] ac, input bit [1:0] pv,
                               input logic [N-1:0][PMP_LEN-1:0] cad,
                               input logic [N-1:0][7:0] cfg);
    for (int i = 0; i < N; i++) begin
      bit     hit;
      longint lo;
      longint hi;
      int     t;
      hit = 1'b0;
      case (cfg[i][4:3])
        2'd1: begin
          if (TOR_EN) begin
            lo  = (i == 0) ? 64'd0 : longint'(cad[i-1]) * 4;
            hi  = longint'(cad[i]) * 4;
            hit = (a >= lo) && (a < hi);
          end
        end
        2'd2: hit = ((a / 4) == longint'(cad[i]));
        2'd3: begin
          t = 0;
          while (t < PMP_LEN && cad[i][t]) t++;
          if (t == PMP_LEN) begin
            hit = 1'b1;
          end else begin
            lo  = ((longint'(cad[i]) >> (t + 1)) << (t + 1)) * 4;
            hi  = lo + (64'd1 << (t + 3));
            hit = (a >= lo) && (a < hi);
          end
        end
        default: hit = 1'b0;
      endcase
      if (hit) begin
        if (pv == 2'b11 && !cfg[i][7]) return 1'b1;
        return ((ac & cfg[i][2:0]) == ac);
      end
    end
    return (pv == 2'b11);
  endfunction

  // Every cycle after the first reset: expected value from inputs present at the edge.
  initial begin
    forever begin
      bit exp;
      @(posedge clk);
      if (cmp_on) begin
        exp = rst ? 1'b0 : model(longint'(addr), acc, priv, ca, cf);
        #1;
        check("cycle_model", allow, exp);
      end
    end
  end

  task automatic expect_next(input string name, input logic exp);
    @(posedge clk);
    #2;
    check(name, allow, exp);
  endtask

  task automatic clear_cfg();
    ca = '0;
    cf = '0;
  endtask

  initial begin
    rst  = 1'b1;
    addr = '0;
    acc  = 3'b001;
    priv = 2'b00;
    clear_cfg();
    @(negedge clk);
    expect_next("reset_state", 1'b0);
    cmp_on = 1'b1;

    // Nested NAPOT regions around 0x19BA, user mode.
    @(negedge clk);
    rst = 1'b0; addr = 34'h19BA; acc = 3'b001; priv = 2'b00;
    ca[2] = 32'h65F; cf[2] = 8'h1F;
    expect_next("napot_e2_rwx_read", 1'b1);
    @(negedge clk);
    ca[1] = 32'h66D; cf[1] = 8'h18;
    expect_next("napot_e1_none_read", 1'b0);
    @(negedge clk);
    ca[0] = 32'h66E; cf[0] = 8'h19;
    expect_next("napot_e0_r_read", 1'b1);
    @(negedge clk);
    acc = 3'b010;
    expect_next("napot_e0_r_write", 1'b0);
    @(negedge clk);
    acc = 3'b000;
    expect_next("napot_e1_none_noaccess", 1'b1);

    // No-match fallback and M-mode lock behaviour.
    @(negedge clk);
    clear_cfg(); addr = '0; acc = 3'b001; priv = 2'b00;
    expect_next("nomatch_u", 1'b0);
    @(negedge clk);
    priv = 2'b11;
    expect_next("nomatch_m", 1'b1);
    @(negedge clk);
    ca[0] = 32'h0; cf[0] = 8'h10;
    expect_next("m_unlocked_none", 1'b1);
    @(negedge clk);
    cf[0] = 8'h90;
    expect_next("m_locked_none", 1'b0);
    @(negedge clk);
    cf[0] = 8'hF6; acc = 3'b100;
    expect_next("m_locked_reserved_wx_exec", 1'b1);

    // TOR range [0x1900, 0x1A00) on entry 1.
    @(negedge clk);
    clear_cfg(); priv = 2'b00; acc = 3'b001;
    ca[0] = 32'h640; ca[1] = 32'h680; cf[1] = 8'h09;
    addr = 34'h19FF;
    expect_next("tor_top_inside", TOR_EN);
    @(negedge clk);
    addr = 34'h1A00;
    expect_next("tor_upper_bound", 1'b0);
    @(negedge clk);
    addr = 34'h18FF;
    expect_next("tor_below_lower", 1'b0);
    @(negedge clk);
    addr = 34'h1900;
    expect_next("tor_lower_bound", TOR_EN);

    // All-ones NAPOT covers the whole space.
    @(negedge clk);
    clear_cfg(); ca[3] = '1; cf[3] = 8'h1B; addr = 34'h3_FFFF_FFFC; acc = 3'b010;
    expect_next("napot_all_ones", 1'b1);

    // Reset overrides an allowing evaluation; first decision one edge after release.
    @(negedge clk);
    clear_cfg(); addr = 34'h19BA; acc = 3'b001; priv = 2'b00;
    ca[2] = 32'h65F; cf[2] = 8'h1F;
    expect_next("pre_reset_allow", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    expect_next("reset_mid_op", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expect_next("after_reset_release", 1'b1);

    // Randomized run around the 0x1800-0x1BFF window.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        for (int e = 0; e < N; e++) begin
          logic [31:0] b;
          logic [31:0] msk;
          b   = 32'h600 + 32'($urandom_range(0, 255));
          msk = (32'd1 << $urandom_range(0, 6)) - 32'd1;
          ca[e] = ($urandom_range(0, 30) == 0) ? '1 : ((b & ~msk) | msk);
          cf[e] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 9) == 0) addr = {2'($urandom_range(0, 3)), 32'($urandom)};
      else                           addr = 34'h1800 + 34'($urandom_range(0, 1023));
      acc = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       priv = 2'b00;
        1:       priv = 2'b01;
        default: priv = 2'b11;
      endcase
      rst = ($urandom_range(0, 49) == 0);
    end

    @(negedge clk);
    cmp_on = 1'b0;
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp.md
PMP -- requirements
Module: pmp

Interface
REQ-001 SHALL have parameter PLEN, default 34, meaning the physical address width in bits.
REQ-002 SHALL have parameter PMP_LEN, default 32, meaning the pmpaddr register width, which holds the address right-shifted by 2.
REQ-003 SHALL have parameter NR_ENTRIES, default 4, meaning the number of PMP entries.
REQ-004 SHALL provide these ports:
- clk_i, input, 1 bit: the single clock.
- rst_i, input, 1 bit: reset, synchronous and active-high.
- addr_i, input, PLEN bits: byte address to check.
- access_type_i, input, 3 bits (riscv::pmp_access_t): ACCESS_READ=001, ACCESS_WRITE=010, ACCESS_EXEC=100.
- priv_lvl_i, input, 2 bits (riscv::priv_lvl_t): U=00, S=01, M=11.
- conf_addr_i, input, NR_ENTRIES x PMP_LEN bits: pmpaddr per entry.
- conf_i, input, NR_ENTRIES x 8 bits (riscv::pmpcfg_t): locked[7], reserved[6:5], addr_mode[4:3] (OFF=0, TOR=1, NA4=2, NAPOT=3), access_type[2:0].
- allow_o, output, 1 bit: access permitted, registered.

Function
REQ-005 SHALL evaluate all entries combinationally and register the final decision into allow_o on the rising clk_i edge, giving 1-cycle latency from any input change.
REQ-006 Mode OFF SHALL never match.
REQ-007 NA4 SHALL match when addr_i[PLEN-1:2] == conf_addr_i[i].
REQ-008 NAPOT SHALL use t = the number of trailing ones in conf_addr_i[i].
- Region size: 2^(t+3) bytes.
- Base: conf_addr_i[i] with its low t+1 bits cleared, shifted left by 2.
- Match: addr_i lies within [base, base+size).
- All-ones conf_addr_i matches every address.
REQ-009 TOR SHALL match when (conf_addr_i[i-1]<<2) <= addr_i < (conf_addr_i[i]<<2), using a lower bound of 0 for entry 0.
- The comparison is unsigned at PLEN width.
- An empty range (lower >= upper) never matches.
REQ-010 Priority SHALL go to the lowest-numbered matching entry; higher-numbered entries SHALL be ignored.
REQ-011 On a match, the permit decision SHALL be (access_type_i & cfg.access_type) == access_type_i, for priv U and S.
REQ-012 On a match in priv M, the access SHALL be permitted when locked=0 and SHALL be checked per REQ-011 when locked=1.
REQ-013 With no matching entry, the access SHALL be permitted only in priv M and denied in U/S.
REQ-014 The reserved cfg bits SHALL be ignored.
REQ-015 access_type_i = 000 SHALL be permitted whenever the entry matches.

Reset
REQ-016 rst_i high at a rising edge SHALL force allow_o=0 (deny) on that edge, overriding any evaluation.
REQ-017 Reset asserted mid-operation SHALL drop allow_o to 0 on the next edge.
REQ-018 The first valid decision SHALL appear on the edge after rst_i deasserts.
REQ-019 The block SHALL hold no state other than the allow_o register.

Configuration
REQ-020 Macro PMP_TOR_EN defined SHALL compile TOR matching per REQ-009.
REQ-021 Without PMP_TOR_EN, an entry in TOR mode SHALL be treated as OFF, i.e. it never matches and lower-priority entries are evaluated.

Verification
All scenarios use priv U and addr 0x19BA unless stated; all other entries are OFF.
REQ-022 Entry2 NAPOT conf_addr=0x65F (0x1900-0x19FF), RWX; READ -> allow_o=1 one cycle later.
REQ-023 Add entry1 NAPOT conf_addr=0x66D (0x19B0-0x19BF), perms 000; READ -> allow_o=0.
REQ-024 Add entry0 NAPOT conf_addr=0x66E (0x19B8-0x19BF), perms R; READ -> 1; WRITE -> 0.
REQ-025 All entries OFF, addr 0x0 -> U gives 0, M gives 1. Entry0 matching with perms 000: locked=0 -> M gives 1; locked=1 -> M gives 0.
REQ-026 With PMP_TOR_EN defined, entry1 TOR and conf_addr[0]=0x640, conf_addr[1]=0x680, perms R:
- addr 0x19FF -> 1.
- addr 0x1A00 -> 0.
- addr 0x18FF -> 0.
REQ-027 With PMP_TOR_EN not defined, the REQ-026 stimulus SHALL give 0 at every address.
REQ-028 rst_i=1 while the input evaluates to allow -> allow_o=0 on that edge; allow_o returns to 1 one edge after rst_i deasserts.
